// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD (double-dabble) converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int         BCD_W          = 4;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    // 10^n, used as the first value that no longer fits in n BCD digits.
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] adjusted
);

    assign adjusted = (digit >= ADD3_THRESHOLD) ? digit + BCD_W'(3) : digit;

endmodule

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble converter: one shift per clock, registered digits held between
// conversions, leading-zero blanking and saturation to all 9s on overflow.
module bin_to_bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) (
    input  logic                    Clk_100MHz,
    input  logic                    Rst_n,
    input  logic [WIDTH-1:0]        bin_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [BCD_W*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]       blank_out,
    output logic                    overflow,
    output logic                    out_valid
);

    localparam int                    CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned           LIMIT      = pow10(DIGITS);
    localparam logic [DIGITS-1:0]     BLANK_ZERO = ~(DIGITS'(1));
    localparam logic [BCD_W*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    state_t                    state;
    logic [WIDTH-1:0]          shift_reg;
    logic [BCD_W*DIGITS-1:0]   scratch;
    logic [CNT_W-1:0]          cnt;
    logic                      ovf_pend;

    logic [BCD_W*DIGITS-1:0]   adjusted;
    logic [BCD_W*DIGITS-1:0]   nxt_scratch;
    logic [WIDTH-1:0]          nxt_shift;
    logic [DIGITS-1:0]         nxt_blank;
    logic                      zero_run;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit    (scratch[g*BCD_W +: BCD_W]),
            .adjusted (adjusted[g*BCD_W +: BCD_W])
        );
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        nxt_scratch = {adjusted[BCD_W*DIGITS-2:0], shift_reg[WIDTH-1]};
        nxt_shift   = shift_reg << 1;
        nxt_blank   = '0;
        zero_run    = 1'b1;
        // Digit i is blank only when it and every more significant digit are zero.
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run && (nxt_scratch[i*BCD_W +: BCD_W] == '0);
            nxt_blank[i] = zero_run;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk_100MHz) begin
        if (!Rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            cnt       <= '0;
            ovf_pend  <= 1'b0;
            bcd_out   <= '0;
            blank_out <= BLANK_ZERO;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= bin_in;
                        scratch   <= '0;
                        cnt       <= '0;
                        ovf_pend  <= (32'(bin_in) >= LIMIT);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= nxt_scratch;
                    shift_reg <= nxt_shift;
                    cnt       <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        bcd_out   <= ovf_pend ? ALL_NINES : nxt_scratch;
                        blank_out <= ovf_pend ? '0 : nxt_blank;
                        overflow  <= ovf_pend;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed self-checking bench for bin_to_bcd_converter (4-digit and 3-digit instances).
module tb_bin_to_bcd_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] bin_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd_out;
    logic [3:0]  blank_out;
    logic        overflow;
    logic        out_valid;

    logic [12:0] bin3;
    logic        valid3;
    logic        ready3;
    logic [11:0] bcd3;
    logic [2:0]  blank3;
    logic        ovf3;
    logic        out_valid3;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] cap_bcd;
    logic [3:0]  cap_blank;
    logic        cap_ovf;
    int          cap_lat;
    int          cap_gap;
    int          cap_pulses;

    always #5 clk = ~clk;

    bin_to_bcd_converter #(.WIDTH(13), .DIGITS(4)) dut (
        .Clk_100MHz (clk),
        .Rst_n      (rst_n),
        .bin_in     (bin_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bcd_out    (bcd_out),
        .blank_out  (blank_out),
        .overflow   (overflow),
        .out_valid  (out_valid)
    );

    bin_to_bcd_converter #(.WIDTH(13), .DIGITS(3)) dut3 (
        .Clk_100MHz (clk),
        .Rst_n      (rst_n),
        .bin_in     (bin3),
        .in_valid   (valid3),
        .in_ready   (ready3),
        .bcd_out    (bcd3),
        .blank_out  (blank3),
        .overflow   (ovf3),
        .out_valid  (out_valid3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept v, then optionally keep requesting with v_during while busy; capture the result.
    task automatic convert(input logic [12:0] v, input logic keep_valid, input logic [12:0] v_during);
        int n;
        bin_in   = v;
        in_valid = 1'b1;
        check("ready_before_accept", 32'(in_ready), 32'd1);
        tick();
        bin_in     = v_during;
        in_valid   = keep_valid;
        cap_lat    = -1;
        cap_pulses = 0;
        n          = 0;
        while (n < 40) begin
            tick();
            n++;
            if (out_valid) begin
                cap_pulses++;
                if (cap_lat < 0) begin
                    cap_lat   = n;
                    cap_bcd   = bcd_out;
                    cap_blank = blank_out;
                    cap_ovf   = overflow;
                end
            end
            if (in_ready) break;
        end
        cap_gap = n + 1;
        if (n >= 40) check("timeout_ready", 32'd0, 32'd1);
    endtask

    task automatic conv3(input logic [12:0] v, input logic [11:0] exp_bcd, input logic exp_ovf);
        int n;
        bin3   = v;
        valid3 = 1'b1;
        tick();
        valid3 = 1'b0;
        n      = 0;
        while (!out_valid3 && n < 40) begin
            tick();
            n++;
        end
        check("d3_latency", 32'(n), 32'd13);
        check("d3_bcd", 32'(bcd3), 32'(exp_bcd));
        check("d3_overflow", 32'(ovf3), 32'(exp_ovf));
        check("d3_blank", 32'(blank3), 32'd0);
        tick();
    endtask

    typedef struct {
        logic [12:0] value;
        logic [15:0] bcd;
        logic [3:0]  blank;
    } vec_t;

    vec_t vecs[5] = '{
        '{13'd9,    16'h0009, 4'b1110},
        '{13'd10,   16'h0010, 4'b1100},
        '{13'd305,  16'h0305, 4'b1000},
        '{13'd1000, 16'h1000, 4'b0000},
        '{13'd5000, 16'h5000, 4'b0000}
    };

    initial begin
        int valid_seen;
        int changes;
        rst_n    = 1'b0;
        bin_in   = '0;
        in_valid = 1'b0;
        bin3     = '0;
        valid3   = 1'b0;
        tick();
        tick();
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_blank", 32'(blank_out), 32'b1110);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Zero
        convert(13'd0, 1'b0, 13'd0);
        check("zero_latency", 32'(cap_lat), 32'd13);
        check("zero_bcd", 32'(cap_bcd), 32'h0);
        check("zero_blank", 32'(cap_blank), 32'b1110);
        check("zero_overflow", 32'(cap_ovf), 32'd0);
        check("zero_pulses", 32'(cap_pulses), 32'd1);

        // Maximum input
        convert(13'd8191, 1'b0, 13'd0);
        check("max_bcd", 32'(cap_bcd), 32'h8191);
        check("max_blank", 32'(cap_blank), 32'b0000);
        check("max_gap", 32'(cap_gap), 32'd15);

        // Back-to-back, request held high and bin_in changed while busy
        convert(13'd1234, 1'b1, 13'd56);
        check("b2b_first_bcd", 32'(cap_bcd), 32'h1234);
        check("b2b_first_blank", 32'(cap_blank), 32'b0000);
        check("b2b_accept_spacing", 32'(cap_gap), 32'd15);
        check("b2b_pulses", 32'(cap_pulses), 32'd1);
        convert(13'd56, 1'b0, 13'd0);
        check("b2b_second_bcd", 32'(cap_bcd), 32'h0056);
        check("b2b_second_blank", 32'(cap_blank), 32'b1100);

        // Directed table
        foreach (vecs[i]) begin
            convert(vecs[i].value, 1'b0, 13'd0);
            check($sformatf("vec%0d_bcd", i), 32'(cap_bcd), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_blank", i), 32'(cap_blank), 32'(vecs[i].blank));
            check($sformatf("vec%0d_latency", i), 32'(cap_lat), 32'd13);
        end

        // Reset during shift 6 of a 4321 conversion
        convert(13'd42, 1'b0, 13'd0);
        bin_in   = 13'd4321;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_bcd", 32'(bcd_out), 32'h0);
        check("midrst_blank", 32'(blank_out), 32'b1110);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        rst_n      = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) valid_seen++;
        end
        check("midrst_no_pulse", 32'(valid_seen), 32'd0);
        check("midrst_bcd_held", 32'(bcd_out), 32'h0);
        convert(13'd7, 1'b0, 13'd0);
        check("after_rst_bcd", 32'(cap_bcd), 32'h0007);
        check("after_rst_blank", 32'(cap_blank), 32'b1110);

        // Overflow on the 3-digit instance
        conv3(13'd1000, 12'h999, 1'b1);
        conv3(13'd999, 12'h999, 1'b0);

        // Output hold
        convert(13'd42, 1'b0, 13'd0);
        check("hold_first_bcd", 32'(cap_bcd), 32'h0042);
        valid_seen = 0;
        changes    = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (out_valid) valid_seen++;
            if (bcd_out !== 16'h0042 || blank_out !== 4'b1100) changes++;
        end
        check("hold_no_pulse", 32'(valid_seen), 32'd0);
        check("hold_no_change", 32'(changes), 32'd0);
        check("hold_bcd", 32'(bcd_out), 32'h0042);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
